// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment counter.
// Contents:
//   digit_t     - one 4-bit digit value
//   SegTable    - active-low a..g patterns for values 0..F (bit 0 = a, bit 6 = g)
//   digit_max() - largest value a digit may hold (9 decimal, F hex)
package seven_seg_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SegTable [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic digit_t digit_max(input bit hex_mode);
        return hex_mode ? 4'hF : 4'h9;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational digit-to-segment decoder, active-low outputs.
// Ports:
//   value - 4-bit digit value to display
//   blank - force a..g off (dp still follows the dp input)
//   dp    - 1 lights the decimal point
//   seg   - segment drive, seg[6:0] = a..g, seg[7] = dp, all active low
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg[7]   = ~dp;
        seg[6:0] = blank ? 7'h7F : SegTable[value];
    end

endmodule

// File: rtl/seven_seg_scan_counter.sv
// N-digit BCD/hex up/down counter driving a time-multiplexed active-low
// seven-segment display with leading-zero blanking, per-digit decimal points
// and a blank window at the start of each digit slot to prevent ghosting.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   step   - count by one this cycle (direction from up)
//   up     - 1 counts up, 0 counts down
//   clr    - synchronous clear, wins over step
//   lzb    - leading-zero blanking enable
//   dp_sel - bit i lights the decimal point of digit i
//   count  - current count, digit i at [4i+3:4i]
//   wrap   - one-cycle pulse on overflow/underflow
//   seg    - active-low segments, [6:0] = a..g, [7] = dp
//   dig    - active-low digit select, one-hot-low or all ones
module seven_seg_scan_counter
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter bit          HEX_MODE     = 1'b0,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic                      up,
    input  logic                      clr,
    input  logic                      lzb,
    input  logic [NUM_DIGITS-1:0]     dp_sel,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      wrap,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PsW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PsW-1:0]  PsLast   = PsW'(SCAN_DIV - 1);
    localparam logic [PsW-1:0]  BlankEnd = PsW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam digit_t          DigitMax = digit_max(HEX_MODE);

    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic [PsW-1:0]          prescaler_q, prescaler_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    // Counter chain: carry/borrow ripples through all digits in one cycle.
    logic   carry;
    digit_t cur_val;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        cur_val = '0;
        if (clr) begin
            count_d = '0;
        end else if (step) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                cur_val = count_q[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (cur_val == DigitMax) begin
                            count_d[4*i +: 4] = '0;
                        end else begin
                            count_d[4*i +: 4] = cur_val + 4'd1;
                            carry             = 1'b0;
                        end
                    end else begin
                        if (cur_val == '0) begin
                            count_d[4*i +: 4] = DigitMax;
                        end else begin
                            count_d[4*i +: 4] = cur_val - 4'd1;
                            carry             = 1'b0;
                        end
                    end
                end
            end
            // Carry surviving past the top digit means every digit wrapped.
            wrap_d = carry;
        end
    end

    // Scan timing.
    always_comb begin
        prescaler_d = (prescaler_q == PsLast) ? '0 : prescaler_q + 1'b1;
        idx_d       = idx_q;
        if (prescaler_q == PsLast) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
    end

    // zero_from[i]: digit i and every digit above it are zero.
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  zero_run;

    always_comb begin
        zero_run  = 1'b1;
        zero_from = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run     = zero_run & (count_q[4*i +: 4] == 4'd0);
            zero_from[i] = zero_run;
        end
    end

    // Digit mux feeding the single decoder.
    digit_t                mux_val;
    logic                  mux_blank;
    logic                  mux_dp;
    logic [NUM_DIGITS-1:0] mux_dig;
    logic [7:0]            dec_seg;

    always_comb begin
        mux_val   = '0;
        mux_blank = 1'b0;
        mux_dp    = 1'b0;
        mux_dig   = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                mux_val    = count_q[4*i +: 4];
                mux_blank  = lzb && (i != 0) && zero_from[i];
                mux_dp     = dp_sel[i];
                mux_dig[i] = 1'b0;
            end
        end
    end

    seven_seg_decode u_decode (
        .value (mux_val),
        .blank (mux_blank),
        .dp    (mux_dp),
        .seg   (dec_seg)
    );

    always_comb begin
        if (prescaler_q < BlankEnd) begin
            seg_d = 8'hFF;
            dig_d = '1;
        end else begin
            seg_d = dec_seg;
            dig_d = mux_dig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            prescaler_q <= '0;
            idx_q       <= '0;
            seg_q       <= 8'hFF;
            dig_q       <= '1;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign seg   = seg_q;
    assign dig   = dig_q;

endmodule

// File: doc/seven_seg_scan_counter.md
# seven_seg_scan_counter

Parametrised N-digit up/down counter with a time-multiplexed 7-segment display driver. It is the multi-digit successor to the single-digit switch-to-segment decoder. It holds a BCD or hex count, scans one digit at a time onto the shared active-low segment bus, and supports leading-zero blanking, per-digit decimal points and anti-ghosting blanking. It sits between board-level control (switches, debounced buttons) and the display pins.

## Interface
Parameters:
- NUM_DIGITS, default 4: number of digits; legal range 1..8.
- HEX_MODE, default 0: each digit is base 10 when 0, base 16 when 1.
- SCAN_DIV, default 50000: clock cycles per digit slot; must be ≥2.
- BLANK_CYCLES, default 1000: cycles at the start of each slot with all digits off; must be < SCAN_DIV.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset, **synchronous, active-high**.
- step, input, 1: count by one on this cycle.
- up, input, 1: direction; 1 counts up, 0 counts down.
- clr, input, 1: synchronous clear of the count.
- lzb, input, 1: leading-zero blanking enable.
- dp_sel, input, NUM_DIGITS: bit i lights the decimal point of digit i.
- count, output, 4*NUM_DIGITS: current count, digit i at bits [4i+3:4i].
- wrap, output, 1: one-cycle pulse on overflow or underflow.
- seg, output, 8: segment drive, active low. seg[0..6] are a..g; seg[7] is dp.
- dig, output, NUM_DIGITS: digit select, active low, one-hot-low or all-ones.

## Operation
Counter:
- clr has priority over step. A clr asserted together with step clears the count and does not pulse wrap.
- Step up: increment digit 0. Carry ripples upward when a digit passes its maximum (9 in decimal, F in hex); the wrapping digit returns to 0.
- Step down: decrement digit 0. Borrow ripples upward when a digit passes below 0; the borrowing digit goes to its maximum.
- All digits at maximum plus one up-step: count becomes all zeros and wrap pulses.
- All digits zero plus one down-step: count becomes all digits at maximum and wrap pulses.
- up is sampled only when step is high.

Scan:
- Prescaler runs 0..SCAN_DIV-1 and wraps.
- On each prescaler wrap, the digit index advances 0→1→…→NUM_DIGITS-1→0.
- While prescaler < BLANK_CYCLES: dig is all ones and seg is 0xFF.
- Otherwise: dig has only bit idx low; seg is the decoded digit idx, and seg[7] is the inverse of dp_sel[idx].

Leading-zero blanking:
- When lzb=1, a digit is blanked (seg[6:0]=all ones) if it and every higher digit are zero.
- Digit 0 is never blanked.
- The dp is unaffected by blanking.

Decode, seg[6:0] active low, for values 0..F:
- 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78
- 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E
- In decimal mode, digit values above 9 cannot occur.

## Timing
- Reset state: count=0, wrap=0, prescaler=0, idx=0, seg=0xFF, dig=all ones.
- count and wrap are registered. A step or clr sampled at edge n is visible after edge n.
- seg and dig are registered from count and idx, so a count change appears on seg one cycle after count changes.
- After rst deasserts, the first BLANK_CYCLES cycles are blank. dig then selects digit 0.
- Reset mid-scan returns idx and prescaler to 0 on the next edge; outputs go blank on that same edge.
- A step during any scan phase is never lost. The display updates within the current slot if that digit is the one being shown.
- Back-to-back step every cycle is supported. The full carry ripple completes in a single cycle.

## Structure
- seven_seg_pkg holds:
  - the 16-entry active-low segment constant table;
  - the digit maximum as a function of HEX_MODE;
  - a typedef for a 4-bit digit.
- Sub-module seven_seg_decode: combinational; maps a 4-bit value, blank flag and dp flag to 8-bit seg. It is instantiated once, after the digit mux.
- The counter chain and the scan/prescaler logic stay in the top module.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, HEX_MODE=0 unless noted.
- **Reset:** hold rst 2 cycles, release → seg=0xFF, dig=4'b1111, count=0x0000. One cycle later: dig=4'b1110, seg=0xC0. Then digits 1, 2, 3 each show seg=0xC0 every 4 cycles.
- **Up overflow:** 9999 steps with up=1 → count=0x9999, wrap never high. One more step → count=0x0000, wrap high for exactly 1 cycle.
- **Down underflow and priority:**
  - From 0x0000, one step with up=0 → count=0x9999 and wrap pulses.
  - clr together with step → count=0x0000, wrap=0.
- **Leading-zero blanking:** count=0x0042, lzb=1, dp_sel=4'b0100.
  - Digit 3 → seg=0xFF.
  - Digit 2 → seg=0x7F (blanked, dp lit).
  - Digit 1 → seg=0x99.
  - Digit 0 → seg=0xA4.
- **Hex mode** (HEX_MODE=1):
  - Count to 0x000F → digit 0 shows seg=0x8E.
  - One more step → count=0x0010, digit 0 shows 0xC0, digit 1 shows 0xF9.
- **Reset mid-scan:** assert rst while idx=2 with prescaler=3 → next edge gives seg=0xFF, dig=4'b1111, count=0. Scan restarts at digit 0.
